fifo_rr_merger: RTL and testbench

- Merges N_INPUTS first-word-fall-through FIFO read ports into one FIFO write port using fair round-robin arbitration.
- Sits between the input SpyBuffers and the output SpyBuffer in a block top level:
  - pops words from the input buffers;
  - writes them, tagged with their source index, into the output buffer;
  - honours the output buffer's almost_full.
- Optional packet mode holds the grant on one input until an end-of-packet word is seen.

---
 rtl/merger_pkg.sv | 41 ++++
 rtl/rr_arbiter.sv | 45 ++++
 rtl/fifo_rr_merger.sv | 120 ++++++++++++
 tb/tb_fifo_rr_merger.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/merger_pkg.sv
// Shared types and helpers for the FIFO round-robin merger.
//   merger_state_t : packet-lock state (IDLE / LOCKED)
//   src_width()    : index width for n inputs, never below 1
//   rr_next()      : first requesting index at or after ptr, wrapping at n
package merger_pkg;

   localparam int unsigned MAX_INPUTS = 16;

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } merger_state_t;

   function automatic int unsigned src_width(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   // Returns 0 when no request is set; callers qualify with |req.
   function automatic logic [3:0] rr_next(input int unsigned n, input logic [3:0] ptr,
                                          input logic [MAX_INPUTS-1:0] req);
      logic [4:0] idx;
      logic       found;
      logic [3:0] gnt;
      idx   = '0;
      found = 1'b0;
      gnt   = '0;
      for (int unsigned k = 0; k < MAX_INPUTS; k++) begin
         if (k < n) begin
            // ptr < n and k < n, so a single subtraction wraps the sum.
            idx = {1'b0, ptr} + 5'(k);
            if (idx >= 5'(n)) idx = idx - 5'(n);
            if (!found && req[idx[3:0]]) begin
               found = 1'b1;
               gnt   = idx[3:0];
            end
         end
      end
      return gnt;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational priority search starting at the
// registered pointer, plus the pointer update.
//   clk_i, rst_ni : clock, synchronous active-low reset
//   req_i         : per-index request
//   advance_i     : on a grant, move the pointer just past the granted index
//   gnt_valid_o   : some request was granted
//   gnt_idx_o     : granted index
//   gnt_o         : one-hot grant
module rr_arbiter import merger_pkg::*; #(
   parameter int unsigned NumReq = 4,
   parameter int unsigned IdxW   = src_width(NumReq)
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic [NumReq-1:0] req_i,
   input  logic              advance_i,
   output logic              gnt_valid_o,
   output logic [IdxW-1:0]   gnt_idx_o,
   output logic [NumReq-1:0] gnt_o
);

   logic [IdxW-1:0]       ptr_q, ptr_d;
   logic [MAX_INPUTS-1:0] req_ext;
   logic [3:0]            gnt_raw;

   always_comb begin
      req_ext               = '0;
      req_ext[NumReq-1:0]   = req_i;
      gnt_raw               = rr_next(NumReq, 4'(ptr_q), req_ext);
      gnt_valid_o           = |req_i;
      gnt_idx_o             = IdxW'(gnt_raw);
      gnt_o                 = gnt_valid_o ? (NumReq'(1) << gnt_idx_o) : '0;

      ptr_d = ptr_q;
      if (gnt_valid_o && advance_i) begin
         ptr_d = (gnt_idx_o == IdxW'(NumReq - 1)) ? '0 : gnt_idx_o + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) ptr_q <= '0;
      else         ptr_q <= ptr_d;
   end

endmodule

// File: rtl/fifo_rr_merger.sv
// Merges N_INPUTS FWFT FIFO read ports into one FIFO write port with fair
// round-robin arbitration; optional packet mode holds the grant until EOP.
//   clock, reset_n   : clock, synchronous active-low reset
//   in_data/in_empty : head word and empty flag of each input FIFO
//   in_read_enable   : pops the granted input (combinational, at most one hot)
//   out_data/out_source/out_write_enable : registered write, one cycle after the pop
//   out_almost_full  : output buffer has at most one free slot
//   word_count       : per-input pop counters (wrapping)
//   locked           : packet lock active
module fifo_rr_merger import merger_pkg::*; #(
   parameter int unsigned DATA_WIDTH  = 256,
   parameter int unsigned N_INPUTS    = 4,
   parameter int unsigned PACKET_MODE = 0,
   parameter int unsigned EOP_BIT     = 255,
   parameter int unsigned CNT_WIDTH   = 32,
   parameter int unsigned SRC_WIDTH   = src_width(N_INPUTS)
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic [DATA_WIDTH-1:0] in_data [N_INPUTS],
   input  logic [N_INPUTS-1:0]   in_empty,
   output logic [N_INPUTS-1:0]   in_read_enable,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [SRC_WIDTH-1:0]  out_source,
   output logic                  out_write_enable,
   input  logic                  out_almost_full,
   output logic [CNT_WIDTH-1:0]  word_count [N_INPUTS],
   output logic                  locked
);

   merger_state_t         state_q, state_d;
   logic [SRC_WIDTH-1:0]  lock_idx_q, lock_idx_d;
   logic [N_INPUTS-1:0]   req, gnt;
   logic                  gnt_valid, gnt_eop, advance;
   logic [SRC_WIDTH-1:0]  gnt_idx;
   logic [DATA_WIDTH-1:0] gnt_data;
   logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
   logic [SRC_WIDTH-1:0]  out_source_q, out_source_d;
   logic                  out_we_q, out_we_d;
   logic [CNT_WIDTH-1:0]  cnt_q [N_INPUTS];
   logic [CNT_WIDTH-1:0]  cnt_d [N_INPUTS];

   // Almost-full is used in the same cycle; its one-slot margin covers the
   // word already in the output register.
   always_comb begin
      for (int i = 0; i < N_INPUTS; i++) begin
         req[i] = reset_n && !in_empty[i] && !out_almost_full &&
                  (state_q == IDLE || lock_idx_q == SRC_WIDTH'(i));
      end
   end

   always_comb begin
      gnt_data = in_data[gnt_idx];
      gnt_eop  = (PACKET_MODE != 0) && gnt_data[EOP_BIT];
      // While a packet is open the pointer stays put; it moves on EOP only.
      advance  = (PACKET_MODE == 0) || gnt_eop;
   end

   rr_arbiter #(
      .NumReq (N_INPUTS),
      .IdxW   (SRC_WIDTH)
   ) u_rr_arbiter (
      .clk_i       (clock),
      .rst_ni      (reset_n),
      .req_i       (req),
      .advance_i   (advance),
      .gnt_valid_o (gnt_valid),
      .gnt_idx_o   (gnt_idx),
      .gnt_o       (gnt)
   );

   always_comb begin
      state_d    = state_q;
      lock_idx_d = lock_idx_q;
      if ((PACKET_MODE != 0) && gnt_valid) begin
         if (gnt_eop) begin
            state_d = IDLE;
         end else begin
            state_d    = LOCKED;
            lock_idx_d = gnt_idx;
         end
      end

      out_we_d     = gnt_valid;
      out_data_d   = gnt_valid ? gnt_data : out_data_q;
      out_source_d = gnt_valid ? gnt_idx : out_source_q;

      for (int i = 0; i < N_INPUTS; i++) begin
         cnt_d[i] = cnt_q[i] + CNT_WIDTH'(gnt[i]);
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         lock_idx_q   <= '0;
         out_we_q     <= 1'b0;
         out_data_q   <= '0;
         out_source_q <= '0;
         for (int i = 0; i < N_INPUTS; i++) cnt_q[i] <= '0;
      end else begin
         state_q      <= state_d;
         lock_idx_q   <= lock_idx_d;
         out_we_q     <= out_we_d;
         out_data_q   <= out_data_d;
         out_source_q <= out_source_d;
         for (int i = 0; i < N_INPUTS; i++) cnt_q[i] <= cnt_d[i];
      end
   end

   always_comb begin
      in_read_enable   = gnt;
      out_write_enable = out_we_q;
      out_data         = out_data_q;
      out_source       = out_source_q;
      locked           = (state_q == LOCKED);
      for (int i = 0; i < N_INPUTS; i++) word_count[i] = cnt_q[i];
   end

endmodule

// File: tb/tb_fifo_rr_merger.sv
// Bench for fifo_rr_merger: instance 0 in word mode (CNT_WIDTH=4), instance 1
// in packet mode. Input FIFOs and a transaction-level arbitration model live
// in the bench; expected writes go into a scoreboard drained by a monitor.
module tb_fifo_rr_merger;

   localparam int unsigned N    = 4;
   localparam int unsigned DW   = 32;
   localparam int unsigned EOPB = 31;
   localparam int unsigned NI   = 2;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic          reset_n = 1'b0;
   logic [DW-1:0] in_data [NI][N];
   logic [N-1:0]  in_empty [NI];
   logic          af [NI];
   wire  [N-1:0]  rd [NI];
   wire  [DW-1:0] odata [NI];
   wire  [1:0]    osrc [NI];
   wire           wen [NI];
   wire           lck [NI];
   wire  [7:0]    wcnt [NI][N];

   for (genvar k = 0; k < NI; k++) begin : g_dut
      localparam int unsigned Cw = (k == 0) ? 4 : 8;
      logic [DW-1:0] d_in [N];
      logic [Cw-1:0] wc [N];
      always_comb begin
         for (int i = 0; i < N; i++) d_in[i] = in_data[k][i];
      end
      for (genvar i = 0; i < N; i++) begin : g_wc
         assign wcnt[k][i] = 8'(wc[i]);
      end
      fifo_rr_merger #(
         .DATA_WIDTH  (DW),
         .N_INPUTS    (N),
         .PACKET_MODE (k),
         .EOP_BIT     (EOPB),
         .CNT_WIDTH   (Cw)
      ) u_dut (
         .clock            (clock),
         .reset_n          (reset_n),
         .in_data          (d_in),
         .in_empty         (in_empty[k]),
         .in_read_enable   (rd[k]),
         .out_data         (odata[k]),
         .out_source       (osrc[k]),
         .out_write_enable (wen[k]),
         .out_almost_full  (af[k]),
         .word_count       (wc),
         .locked           (lck[k])
      );
   end

   // Reference state
   logic [DW-1:0]   fifo_q [NI][N][$];
   logic [DW+1:0]   exp_q [NI][$];
   int unsigned     src_log [NI][$];
   int unsigned     m_ptr [NI];
   bit              m_lock [NI];
   int unsigned     m_lidx [NI];
   int unsigned     m_cnt [NI][N];
   int unsigned     n_tests = 0;
   int unsigned     n_fail = 0;
   logic [DW+1:0]   mon_e;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   function automatic logic [DW-1:0] mkw(input bit eop);
      return {eop, 31'($urandom)};
   endfunction

   task automatic model_reset();
      for (int k = 0; k < NI; k++) begin
         m_ptr[k]  = 0;
         m_lock[k] = 1'b0;
         m_lidx[k] = 0;
         for (int i = 0; i < N; i++) m_cnt[k][i] = 0;
      end
   endtask

   // One clock cycle: check registered state, drive inputs, predict the grant.
   task automatic cycle(input bit rst_n, input bit [NI-1:0] afv);
      int            g;
      int unsigned   idx;
      logic [DW-1:0] w;
      @(negedge clock);
      for (int k = 0; k < NI; k++) begin
         check($sformatf("locked[%0d]", k), 64'(lck[k]), 64'(m_lock[k]));
         for (int i = 0; i < N; i++) begin
            check($sformatf("word_count[%0d][%0d]", k, i), 64'(wcnt[k][i]), 64'(m_cnt[k][i]));
         end
      end
      #1;
      reset_n = rst_n;
      for (int k = 0; k < NI; k++) begin
         af[k] = afv[k];
         for (int i = 0; i < N; i++) begin
            in_empty[k][i] = (fifo_q[k][i].size() == 0);
            in_data[k][i]  = in_empty[k][i] ? DW'($urandom) : fifo_q[k][i][0];
         end
      end
      #1;
      if (!rst_n) begin
         for (int k = 0; k < NI; k++) check($sformatf("rd_in_reset[%0d]", k), 64'(rd[k]), 64'd0);
         model_reset();
      end else begin
         for (int k = 0; k < NI; k++) begin
            g = -1;
            if (!afv[k]) begin
               for (int j = 0; j < N; j++) begin
                  idx = (m_ptr[k] + j) % N;
                  if (g < 0 && fifo_q[k][idx].size() != 0 && (!m_lock[k] || idx == m_lidx[k]))
                     g = int'(idx);
               end
            end
            check($sformatf("in_read_enable[%0d]", k), 64'(rd[k]), (g < 0) ? 64'd0 : (64'd1 << g));
            if (g >= 0) begin
               w = fifo_q[k][g].pop_front();
               exp_q[k].push_back({2'(g), w});
               m_cnt[k][g] = (m_cnt[k][g] + 1) % ((k == 0) ? 16 : 256);
               if (k == 1 && !w[EOPB]) begin
                  m_lock[k] = 1'b1;
                  m_lidx[k] = g;
               end else begin
                  m_lock[k] = 1'b0;
                  m_ptr[k]  = (g + 1) % N;
               end
            end
         end
      end
   endtask

   // Monitor: every write must match the oldest outstanding prediction.
   always @(negedge clock) begin
      for (int k = 0; k < NI; k++) begin
         if (wen[k] === 1'b1) begin
            if (exp_q[k].size() == 0) begin
               check($sformatf("unexpected_write[%0d]", k), 64'd1, 64'd0);
            end else begin
               mon_e = exp_q[k].pop_front();
               check($sformatf("out_source[%0d]", k), 64'(osrc[k]), 64'(mon_e[DW+1:DW]));
               check($sformatf("out_data[%0d]", k), 64'(odata[k]), 64'(mon_e[DW-1:0]));
               src_log[k].push_back(int'(osrc[k]));
            end
         end else if (exp_q[k].size() != 0) begin
            check($sformatf("missing_write[%0d]", k), 64'd0, 64'd1);
            exp_q[k].delete();
         end
      end
   end

   initial begin
      for (int k = 0; k < NI; k++) begin
         af[k]       = 1'b0;
         in_empty[k] = '1;
         for (int i = 0; i < N; i++) in_data[k][i] = '0;
      end
      model_reset();
      repeat (2) cycle(1'b0, '0);
      for (int k = 0; k < NI; k++) begin
         check($sformatf("reset_wen[%0d]", k), 64'(wen[k]), 64'd0);
         check($sformatf("reset_data[%0d]", k), 64'(odata[k]), 64'd0);
         check($sformatf("reset_src[%0d]", k), 64'(osrc[k]), 64'd0);
      end

      // Word mode: every input holds 3 words
      src_log[0].delete();
      for (int i = 0; i < N; i++) repeat (3) fifo_q[0][i].push_back(mkw(1'b0));
      repeat (16) cycle(1'b1, '0);
      check("rotation_len", 64'(src_log[0].size()), 64'd12);
      if (src_log[0].size() == 12) begin
         for (int j = 0; j < 12; j++) check($sformatf("rotation[%0d]", j), 64'(src_log[0][j]), 64'(j % 4));
      end
      for (int i = 0; i < N; i++) check($sformatf("count3[%0d]", i), 64'(wcnt[0][i]), 64'd3);

      // Single busy input
      repeat (5) fifo_q[0][2].push_back(mkw(1'b0));
      repeat (8) cycle(1'b1, '0);
      check("single_input_count", 64'(wcnt[0][2]), 64'd8);

      // Backpressure window in the middle of a stream
      for (int i = 0; i < N; i++) repeat (4) fifo_q[0][i].push_back(mkw(1'b0));
      for (int c = 0; c < 24; c++) cycle(1'b1, (c >= 4 && c <= 7) ? 2'b01 : 2'b00);

      // Packet mode: 4-word packet on input 0, 1-word packet on input 1
      src_log[1].delete();
      for (int j = 0; j < 4; j++) fifo_q[1][0].push_back(mkw(j == 3));
      fifo_q[1][1].push_back(mkw(1'b1));
      repeat (8) cycle(1'b1, '0);
      check("pkt_order_len", 64'(src_log[1].size()), 64'd5);
      if (src_log[1].size() == 5) begin
         for (int j = 0; j < 5; j++)
            check($sformatf("pkt_order[%0d]", j), 64'(src_log[1][j]), (j == 4) ? 64'd1 : 64'd0);
      end

      // Locked input runs dry: input 1 must wait
      repeat (2) fifo_q[1][0].push_back(mkw(1'b0));
      fifo_q[1][1].push_back(mkw(1'b1));
      repeat (6) cycle(1'b1, '0);
      check("stall_locked", 64'(lck[1]), 64'd1);
      check("stall_in1_count", 64'(wcnt[1][1]), 64'd1);
      fifo_q[1][0].push_back(mkw(1'b1));
      repeat (4) cycle(1'b1, '0);
      check("after_stall_in1_count", 64'(wcnt[1][1]), 64'd2);

      // Reset while a packet is open
      repeat (3) fifo_q[1][0].push_back(mkw(1'b0));
      fifo_q[1][1].push_back(mkw(1'b1));
      repeat (2) cycle(1'b1, '0);
      cycle(1'b0, '0);
      @(posedge clock);
      #1;
      check("rst_locked", 64'(lck[1]), 64'd0);
      check("rst_wen", 64'(wen[1]), 64'd0);
      for (int i = 0; i < N; i++) check($sformatf("rst_count[%0d]", i), 64'(wcnt[1][i]), 64'd0);
      src_log[1].delete();
      fifo_q[1][0].push_back(mkw(1'b1));
      repeat (6) cycle(1'b1, '0);
      check("restart_len", 64'(src_log[1].size()), 64'd3);
      if (src_log[1].size() == 3) check("restart_first", 64'(src_log[1][0]), 64'd0);

      // Counter wrap at CNT_WIDTH=4
      cycle(1'b0, '0);
      repeat (17) fifo_q[0][3].push_back(mkw(1'b0));
      repeat (20) cycle(1'b1, '0);
      check("count_wrap", 64'(wcnt[0][3]), 64'd1);

      // Random traffic, backpressure and occasional reset
      for (int c = 0; c < 400; c++) begin
         for (int k = 0; k < NI; k++) begin
            if ($urandom_range(0, 2) != 0) begin
               int unsigned i;
               i = $urandom_range(0, N - 1);
               if (fifo_q[k][i].size() < 6) fifo_q[k][i].push_back(mkw($urandom_range(0, 2) == 0));
            end
         end
         cycle($urandom_range(0, 99) != 0,
               {$urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0});
      end
      repeat (40) cycle(1'b1, '0);

      @(negedge clock);
      #1;
      for (int k = 0; k < NI; k++) check($sformatf("scoreboard_empty[%0d]", k), 64'(exp_q[k].size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
